// File: rtl/shoe_shuffler.sv
`default_nettype none
// =============================================================================
// shoe_shuffler : builds a multi-deck card shoe, Fisher-Yates shuffles it
//                 in place with a 16-bit LFSR and deals it over valid/ready.
// Revision      : 1.0
// =============================================================================
module shoe_shuffler #(
    parameter int          CARDS_PER_DECK = 52,
    parameter int          NUM_DECKS      = 1,
    parameter int          CUT_LEVEL      = 13,
    parameter logic [15:0] SEED           = 16'hACE1,
    localparam int         N              = CARDS_PER_DECK * NUM_DECKS,
    localparam int         IDX_W          = (N > 1) ? $clog2(N) : 1,
    localparam int         CARD_W         = $clog2(CARDS_PER_DECK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shuffle_req,
    output logic              busy,
    output logic              shuffle_done,
    output logic              card_valid,
    input  logic              card_ready,
    output logic [CARD_W-1:0] card_data,
    output logic [IDX_W:0]    remaining,
    output logic              low_water,
    output logic              empty
);

    localparam logic [15:0]       SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
    localparam logic [CARD_W-1:0] LAST_VAL = CARD_W'(CARDS_PER_DECK - 1);
    localparam logic [IDX_W:0]    FULL_CNT = (IDX_W + 1)'(N);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_INIT    = 2'd1,
        S_SHUFFLE = 2'd2,
        S_DEAL    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [CARD_W-1:0]   shoe_q [N];
    logic [CARD_W-1:0]   shoe_d [N];
    logic [IDX_W-1:0]    k_q, k_d;
    logic [CARD_W-1:0]   val_q, val_d;
    logic [IDX_W-1:0]    i_q, i_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W:0]      remaining_q, remaining_d;
    logic                busy_q, busy_d;
    logic                shuffle_done_q, shuffle_done_d;
    logic                card_valid_q, card_valid_d;
    logic [CARD_W-1:0]   card_data_q, card_data_d;
    logic                low_water_q, low_water_d;
    logic                empty_q, empty_d;
    logic [IDX_W-1:0]    draw;

    // Smearing the value right gives the smallest all-ones mask covering it.
    function automatic logic [IDX_W-1:0] fill_mask(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] m;
        m = v;
        for (int s = 1; s < IDX_W; s++) begin
            m = m | (v >> s);
        end
        return m;
    endfunction

    always_comb begin
        state_d        = state_q;
        lfsr_d         = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        shoe_d         = shoe_q;
        k_d            = k_q;
        val_d          = val_q;
        i_d            = i_q;
        ptr_d          = ptr_q;
        remaining_d    = remaining_q;
        shuffle_done_d = 1'b0;
        draw           = lfsr_q[IDX_W-1:0] & fill_mask(i_q);

        case (state_q)
            S_IDLE: begin
                if (shuffle_req) begin
                    state_d = S_INIT;
                    k_d     = '0;
                    val_d   = '0;
                end
            end
            S_INIT: begin
                shoe_d[k_q] = val_q;
                k_d         = k_q + 1'b1;
                val_d       = (val_q == LAST_VAL) ? '0 : val_q + 1'b1;
                if (k_q == LAST_IDX) begin
                    i_d = LAST_IDX;
                    if (N == 1) begin
                        state_d        = S_DEAL;
                        ptr_d          = '0;
                        remaining_d    = FULL_CNT;
                        shuffle_done_d = 1'b1;
                    end else begin
                        state_d = S_SHUFFLE;
                    end
                end
            end
            S_SHUFFLE: begin
                // Draws above i are rejected so every swap target stays uniform.
                if (draw <= i_q) begin
                    shoe_d[i_q]  = shoe_q[draw];
                    shoe_d[draw] = shoe_q[i_q];
                    i_d          = i_q - 1'b1;
                    if (i_q == IDX_W'(1)) begin
                        state_d        = S_DEAL;
                        ptr_d          = '0;
                        remaining_d    = FULL_CNT;
                        shuffle_done_d = 1'b1;
                    end
                end
            end
            S_DEAL: begin
                if (shuffle_req) begin
                    state_d = S_INIT;
                    k_d     = '0;
                    val_d   = '0;
                end else if (card_valid_q && card_ready) begin
                    ptr_d       = ptr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d       = (state_d == S_INIT) || (state_d == S_SHUFFLE);
        card_valid_d = (state_d == S_DEAL) && (remaining_d != '0);
        card_data_d  = card_valid_d ? shoe_d[ptr_d] : '0;
        low_water_d  = (state_d == S_DEAL) && (32'(remaining_d) <= CUT_LEVEL);
        empty_d      = (state_d == S_DEAL) && (remaining_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            lfsr_q         <= SEED_EFF;
            shoe_q         <= '{default: '0};
            k_q            <= '0;
            val_q          <= '0;
            i_q            <= '0;
            ptr_q          <= '0;
            remaining_q    <= '0;
            busy_q         <= 1'b0;
            shuffle_done_q <= 1'b0;
            card_valid_q   <= 1'b0;
            card_data_q    <= '0;
            low_water_q    <= 1'b0;
            empty_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            shoe_q         <= shoe_d;
            k_q            <= k_d;
            val_q          <= val_d;
            i_q            <= i_d;
            ptr_q          <= ptr_d;
            remaining_q    <= remaining_d;
            busy_q         <= busy_d;
            shuffle_done_q <= shuffle_done_d;
            card_valid_q   <= card_valid_d;
            card_data_q    <= card_data_d;
            low_water_q    <= low_water_d;
            empty_q        <= empty_d;
        end
    end

    assign busy         = busy_q;
    assign shuffle_done = shuffle_done_q;
    assign card_valid   = card_valid_q;
    assign card_data    = card_data_q;
    assign remaining    = remaining_q;
    assign low_water    = low_water_q;
    assign empty        = empty_q;

endmodule
`default_nettype wire

// File: tb/tb_shoe_shuffler.sv
`default_nettype none
// =============================================================================
// tb_shoe_shuffler : directed self-checking bench for shoe_shuffler
// Revision         : 1.0
// =============================================================================
module tb_shoe_shuffler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // a and c share stimulus and differ only in SEED; b is a two-deck shoe.
    logic       a_req = 1'b0, a_rdy = 1'b0;
    logic       a_busy, a_done, a_valid, a_low, a_empty;
    logic [5:0] a_data;
    logic [6:0] a_rem;
    logic       c_busy, c_done, c_valid, c_low, c_empty;
    logic [5:0] c_data;
    logic [6:0] c_rem;
    logic       b_req = 1'b0, b_rdy = 1'b0;
    logic       b_busy, b_done, b_valid, b_low, b_empty;
    logic [5:0] b_data;
    logic [7:0] b_rem;

    int errors = 0;
    int checks = 0;
    int edge_cnt;
    int req_edge;
    int exp_seq [0:103];
    logic [5:0] seq_a [0:51];
    logic [5:0] seq_c [0:51];
    logic [5:0] run1  [0:51];
    logic [5:0] seq_b [0:103];

    shoe_shuffler #(.CARDS_PER_DECK(52), .NUM_DECKS(1), .CUT_LEVEL(13), .SEED(16'hACE1)) dut_a (
        .clk(clk), .rst(rst), .shuffle_req(a_req), .busy(a_busy), .shuffle_done(a_done),
        .card_valid(a_valid), .card_ready(a_rdy), .card_data(a_data), .remaining(a_rem),
        .low_water(a_low), .empty(a_empty));

    shoe_shuffler #(.CARDS_PER_DECK(52), .NUM_DECKS(1), .CUT_LEVEL(13), .SEED(16'hBEEF)) dut_c (
        .clk(clk), .rst(rst), .shuffle_req(a_req), .busy(c_busy), .shuffle_done(c_done),
        .card_valid(c_valid), .card_ready(a_rdy), .card_data(c_data), .remaining(c_rem),
        .low_water(c_low), .empty(c_empty));

    shoe_shuffler #(.CARDS_PER_DECK(52), .NUM_DECKS(2), .CUT_LEVEL(13), .SEED(16'hACE1)) dut_b (
        .clk(clk), .rst(rst), .shuffle_req(b_req), .busy(b_busy), .shuffle_done(b_done),
        .card_valid(b_valid), .card_ready(b_rdy), .card_data(b_data), .remaining(b_rem),
        .low_water(b_low), .empty(b_empty));

    // Number of LFSR advances since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference Fisher-Yates; lfsr value at first SHUFFLE cycle is SEED advanced 'steps' times.
    task automatic model_shuffle(input int n, input int cpd, input int idxw,
                                 input logic [15:0] seed, input int steps);
        logic [15:0] v;
        int i, r, m, tmp;
        v = seed;
        for (int s = 0; s < steps; s++) v = lfsr_step(v);
        for (int k = 0; k < n; k++) exp_seq[k] = k % cpd;
        i = n - 1;
        while (i >= 1) begin
            m = 1;
            while (m - 1 < i) m = m * 2;
            r = int'(v) & ((1 << idxw) - 1) & (m - 1);
            if (r <= i) begin
                tmp = exp_seq[i]; exp_seq[i] = exp_seq[r]; exp_seq[r] = tmp;
                i--;
            end
            v = lfsr_step(v);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; a_req = 1'b0; a_rdy = 1'b0; b_req = 1'b0; b_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_a_req(input int pre);
        repeat (pre) @(negedge clk);
        a_req = 1'b1;
        @(posedge clk);
        #1;
        req_edge = edge_cnt;
        a_req = 1'b0;
        checks++;
        if (a_busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_req: busy=%b expected 1", a_busy);
        end
    endtask

    task automatic wait_done_a();
        bit seen;
        seen = 1'b0;
        a_rdy = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (a_done) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL shuffle_done_timeout: not seen in 2000 cycles"); end
        checks++;
        if ({a_busy, a_valid, a_rem} !== {1'b0, 1'b1, 7'd52}) begin
            errors++;
            $display("FAIL first_deal_cycle: busy=%b valid=%b remaining=%0d expected 0 1 52",
                     a_busy, a_valid, a_rem);
        end
    endtask

    task automatic deal_ac(input bit with_c);
        int na, nc;
        na = 0; nc = 0;
        a_rdy = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (c == 1) begin
                checks++;
                if (a_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: shuffle_done=%b expected 0", a_done); end
            end
            if (a_valid && na < 52) begin
                checks++;
                if (a_rem !== 7'(52 - na)) begin
                    errors++; $display("FAIL deal_remaining: card %0d remaining=%0d expected %0d", na, a_rem, 52 - na);
                end
                seq_a[na] = a_data; na++;
            end
            if (with_c && c_valid && nc < 52) begin seq_c[nc] = c_data; nc++; end
            if (na == 52 && (!with_c || nc == 52)) break;
            @(negedge clk);
        end
        checks++;
        if (na != 52 || (with_c && nc != 52)) begin
            errors++; $display("FAIL deal_count: dealt a=%0d c=%0d expected 52", na, nc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_busy, a_done, a_valid, a_data, a_rem, a_low, a_empty} !== '0) begin
            errors++; $display("FAIL reset_outputs_a: busy=%b done=%b valid=%b data=%0d rem=%0d low=%b empty=%b expected all 0",
                               a_busy, a_done, a_valid, a_data, a_rem, a_low, a_empty);
        end
        checks++;
        if ({b_busy, b_done, b_valid, b_data, b_rem, b_low, b_empty} !== '0) begin
            errors++; $display("FAIL reset_outputs_b: busy=%b valid=%b rem=%0d expected 0", b_busy, b_valid, b_rem);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_busy, a_valid, a_rem, a_low, a_empty, c_busy, c_done, c_low, c_empty, c_rem} !== '0) begin
            errors++; $display("FAIL idle_outputs: busy=%b valid=%b rem=%0d low=%b empty=%b expected 0",
                               a_busy, a_valid, a_rem, a_low, a_empty);
        end
    endtask

    task automatic test_single_deck();
        int hist [0:51];
        int bad;
        do_reset();
        pulse_a_req(4);
        wait_done_a();
        deal_ac(1'b1);
        @(negedge clk);
        checks++;
        if ({a_empty, a_valid, a_rem, a_low} !== {1'b1, 1'b0, 7'd0, 1'b1}) begin
            errors++; $display("FAIL empty_state: empty=%b valid=%b rem=%0d low=%b expected 1 0 0 1",
                               a_empty, a_valid, a_rem, a_low);
        end
        for (int v = 0; v < 52; v++) hist[v] = 0;
        for (int k = 0; k < 52; k++) if (seq_a[k] < 52) hist[seq_a[k]]++;
        bad = 0;
        for (int v = 0; v < 52; v++) if (hist[v] != 1) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL one_deck_histogram: %0d values not seen exactly once, expected 0", bad); end
        model_shuffle(52, 52, 6, 16'hACE1, req_edge + 52);
        bad = 0;
        for (int k = 0; k < 52; k++) if (32'(seq_a[k]) != exp_seq[k]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL seq_seed_ace1: %0d positions differ, card0=%0d expected %0d", bad, seq_a[0], exp_seq[0]); end
        model_shuffle(52, 52, 6, 16'hBEEF, req_edge + 52);
        bad = 0;
        for (int k = 0; k < 52; k++) if (32'(seq_c[k]) != exp_seq[k]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL seq_seed_beef: %0d positions differ, card0=%0d expected %0d", bad, seq_c[0], exp_seq[0]); end
        for (int k = 0; k < 52; k++) run1[k] = seq_a[k];
    endtask

    task automatic test_two_decks();
        int hist [0:51];
        int bad, nb, e;
        bit seen;
        do_reset();
        repeat (4) @(negedge clk);
        b_req = 1'b1;
        @(posedge clk);
        #1;
        e = edge_cnt;
        b_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (b_done) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen || b_rem !== 8'd104) begin errors++; $display("FAIL two_deck_start: done_seen=%b rem=%0d expected 1 104", seen, b_rem); end
        b_rdy = 1'b1;
        nb = 0;
        for (int c = 0; c < 400 && nb < 104; c++) begin
            if (b_valid) begin
                checks++;
                if (b_rem !== 8'(104 - nb) || b_low !== (104 - nb <= 13)) begin
                    errors++; $display("FAIL two_deck_low_water: rem=%0d low=%b expected rem %0d low %b",
                                       b_rem, b_low, 104 - nb, (104 - nb <= 13));
                end
                seq_b[nb] = b_data; nb++;
            end
            if (nb < 104) @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (nb != 104 || b_empty !== 1'b1 || b_valid !== 1'b0) begin
            errors++; $display("FAIL two_deck_count: dealt=%0d empty=%b valid=%b expected 104 1 0", nb, b_empty, b_valid);
        end
        for (int v = 0; v < 52; v++) hist[v] = 0;
        for (int k = 0; k < 104; k++) if (seq_b[k] < 52) hist[seq_b[k]]++;
        bad = 0;
        for (int v = 0; v < 52; v++) if (hist[v] != 2) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL two_deck_histogram: %0d values not seen exactly twice, expected 0", bad); end
        model_shuffle(104, 52, 7, 16'hACE1, e + 104);
        bad = 0;
        for (int k = 0; k < 104; k++) if (32'(seq_b[k]) != exp_seq[k]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL two_deck_sequence: %0d positions differ, expected 0", bad); end
        b_rdy = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [5:0] d0;
        do_reset();
        pulse_a_req(4);
        wait_done_a();
        d0 = a_data;
        checks++;
        if (d0 !== run1[0]) begin errors++; $display("FAIL bp_first_card: data=%0d expected %0d", d0, run1[0]); end
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (a_data !== d0 || a_rem !== 7'd52 || a_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold: data=%0d rem=%0d valid=%b expected %0d 52 1", a_data, a_rem, a_valid, d0);
            end
        end
        a_rdy = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (a_rem !== 7'(52 - k) || a_data !== run1[k]) begin
                errors++; $display("FAIL bp_release: rem=%0d data=%0d expected %0d %0d", a_rem, a_data, 52 - k, run1[k]);
            end
        end
        a_rdy = 1'b0;
    endtask

    task automatic test_back_to_back_reshuffle();
        int bad;
        do_reset();
        pulse_a_req(4);
        wait_done_a();
        a_rdy = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (a_rem !== 7'd32) begin errors++; $display("FAIL reshuffle_pre: rem=%0d expected 32", a_rem); end
        a_req = 1'b1;
        @(posedge clk);
        #1;
        req_edge = edge_cnt;
        a_req = 1'b0;
        a_rdy = 1'b0;
        checks++;
        if ({a_rem, a_busy, a_valid, a_low} !== {7'd32, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reshuffle_wins: rem=%0d busy=%b valid=%b low=%b expected 32 1 0 0",
                               a_rem, a_busy, a_valid, a_low);
        end
        repeat (5) @(negedge clk);
        a_req = 1'b1;
        @(negedge clk);
        a_req = 1'b0;
        checks++;
        if (a_busy !== 1'b1) begin errors++; $display("FAIL req_while_busy: busy=%b expected 1", a_busy); end
        wait_done_a();
        deal_ac(1'b0);
        model_shuffle(52, 52, 6, 16'hACE1, req_edge + 52);
        bad = 0;
        for (int k = 0; k < 52; k++) if (32'(seq_a[k]) != exp_seq[k]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reshuffle_sequence: %0d positions differ, expected 0", bad); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        pulse_a_req(4);
        repeat (60) @(negedge clk);
        checks++;
        if (a_busy !== 1'b1) begin errors++; $display("FAIL mid_shuffle_busy: busy=%b expected 1", a_busy); end
        rst = 1'b1;
        #1;
        checks++;
        if ({a_busy, a_valid, a_rem, a_done} !== '0) begin
            errors++; $display("FAIL async_reset: busy=%b valid=%b rem=%0d expected 0 0 0", a_busy, a_valid, a_rem);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({a_busy, a_valid, a_rem, a_empty} !== '0) begin
            errors++; $display("FAIL post_reset_idle: busy=%b valid=%b rem=%0d empty=%b expected 0", a_busy, a_valid, a_rem, a_empty);
        end
    endtask

    task automatic test_determinism();
        int same, diff;
        do_reset();
        pulse_a_req(4);
        wait_done_a();
        deal_ac(1'b1);
        same = 0; diff = 0;
        for (int k = 0; k < 52; k++) begin
            if (seq_a[k] === run1[k]) same++;
            if (seq_c[k] !== run1[k]) diff++;
        end
        checks++;
        if (same != 52) begin errors++; $display("FAIL repeat_run: %0d of 52 cards match, expected 52", same); end
        checks++;
        if (diff == 0) begin errors++; $display("FAIL seed_changes_sequence: %0d cards differ, expected at least 1", diff); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_deck();
        test_two_decks();
        test_backpressure();
        test_back_to_back_reshuffle();
        test_mid_reset();
        test_determinism();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
